// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - core data bus and host image-load bus bundle for data_mem_ctrl
interface data_mem_ctrl_if;
    logic        MemWrite;
    logic        ByteMem;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        load_valid;
    logic [7:0]  load_data;
    logic        load_last;
    logic        load_ready;
    logic        start;
    logic        done;

    modport master (
        output MemWrite, ByteMem, ALUResult, WriteData,
        output load_valid, load_data, load_last,
        input  ReadData, load_ready, start, done
    );

    modport slave (
        input  MemWrite, ByteMem, ALUResult, WriteData,
        input  load_valid, load_data, load_last,
        output ReadData, load_ready, start, done
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - data RAM, byte lanes, MMIO halt/cycle regs and host image loader
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h0001_0000
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned   AW       = $clog2(DEPTH_WORDS);
    localparam logic [AW+1:0] LAST_PTR = '1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [31:0]    r_mem [DEPTH_WORDS];
    logic [AW+1:0]  r_ptr;
    logic [31:0]    r_cycles;

    logic           w_in_ram;
    logic           w_is_halt;
    logic           w_is_cyc;
    logic [AW-1:0]  w_core_idx;
    logic [1:0]     w_core_lane;
    logic           w_accept;
    logic           w_halt_wr;
    logic [31:0]    w_rd_word;
    logic [7:0]     w_rd_byte;
    logic [31:0]    w_mmio_val;

    logic           w_we;
    logic [AW-1:0]  w_widx;
    logic [3:0]     w_wmask;
    logic [31:0]    w_wdata;

    // Address decode: RAM wins if it were ever sized to overlap the MMIO window
    assign w_in_ram    = (bus.ALUResult >> (AW + 2)) == 32'd0;
    assign w_is_halt   = bus.ALUResult[31:2] == MMIO_BASE[31:2];
    assign w_is_cyc    = bus.ALUResult[31:2] == (MMIO_BASE[31:2] + 30'd1);
    assign w_core_idx  = bus.ALUResult[AW+1:2];
    assign w_core_lane = bus.ALUResult[1:0];

    assign w_accept  = (r_state == ST_LOAD) && bus.load_valid;
    assign w_halt_wr = (r_state == ST_RUN) && bus.MemWrite && !w_in_ram && w_is_halt;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake/run outputs
    always_comb begin
        w_next_state   = r_state;
        bus.load_ready = 1'b0;
        bus.start      = 1'b0;
        bus.done       = 1'b0;
        case (r_state)
            ST_LOAD: begin
                bus.load_ready = 1'b1;
                if (w_accept && (bus.load_last || r_ptr == LAST_PTR)) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                bus.start = 1'b1;
                if (w_halt_wr) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                w_next_state = ST_LOAD;
            end
        endcase
    end

    // Load pointer and saturating run-cycle counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr    <= '0;
            r_cycles <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (r_state == ST_RUN && r_cycles != 32'hFFFF_FFFF) begin
                r_cycles <= r_cycles + 32'd1;
            end
        end
    end

    // Single RAM write port shared by the host loader and core stores
    always_comb begin
        w_we    = 1'b0;
        w_widx  = w_core_idx;
        w_wmask = 4'b0000;
        w_wdata = bus.WriteData;
        if (w_accept) begin
            w_we    = 1'b1;
            w_widx  = r_ptr[AW+1:2];
            w_wmask = 4'b0001 << r_ptr[1:0];
            w_wdata = {4{bus.load_data}};
        end else if (r_state == ST_RUN && bus.MemWrite && w_in_ram) begin
            w_we = 1'b1;
            if (bus.ByteMem) begin
                w_wmask = 4'b0001 << w_core_lane;
                w_wdata = {4{bus.WriteData[7:0]}};
            end else begin
                w_wmask = 4'b1111;
            end
        end
    end

    // RAM storage: byte-lane writes, contents survive reset
    always_ff @(posedge clk) begin
        if (reset && w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_core_idx];
    assign w_rd_byte = w_rd_word[8*w_core_lane +: 8];

    // Combinational load data: RAM, MMIO registers, or zero for unmapped space
    always_comb begin
        w_mmio_val   = 32'd0;
        bus.ReadData = 32'd0;
        if (w_is_halt) begin
            w_mmio_val = {31'd0, r_state == ST_DONE};
        end else if (w_is_cyc) begin
            w_mmio_val = r_cycles;
        end
        if (w_in_ram) begin
            bus.ReadData = bus.ByteMem ? {24'd0, w_rd_byte} : w_rd_word;
        end else if (w_is_halt || w_is_cyc) begin
            bus.ReadData = bus.ByteMem ? {24'd0, w_mmio_val[7:0]} : w_mmio_val;
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl against a byte-array model
module tb_data_mem_ctrl;
    localparam int          DEPTH = 1024;
    localparam int          NB    = DEPTH * 4;
    localparam logic [31:0] MB    = 32'h0001_0000;
    localparam int          S_LOAD = 0;
    localparam int          S_RUN  = 1;
    localparam int          S_DONE = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus();

    data_mem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .MMIO_BASE   (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0]  m_mem [NB];
    int          m_state;
    int          m_ptr;
    logic [31:0] m_cycles;
    int          n_total = 0;
    int          n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic bm);
        logic [31:0] v;
        logic [11:0] b;
        if (a < NB) begin
            b = a[11:0];
            if (bm) return {24'h0, m_mem[b]};
            b[1:0] = 2'b00;
            return {m_mem[b+3], m_mem[b+2], m_mem[b+1], m_mem[b]};
        end
        if ((a >> 2) == (MB >> 2)) v = {31'h0, m_state == S_DONE};
        else if ((a >> 2) == ((MB >> 2) + 1)) v = m_cycles;
        else return 32'h0;
        return bm ? {24'h0, v[7:0]} : v;
    endfunction

    // Apply the spec rules for one clock edge to the model, then advance and check status outputs
    task automatic step();
        logic [31:0] a;
        a = bus.ALUResult;
        if (!reset) begin
            m_state = S_LOAD; m_ptr = 0; m_cycles = 0;
        end else if (m_state == S_LOAD) begin
            if (bus.load_valid) begin
                m_mem[m_ptr] = bus.load_data;
                if (bus.load_last || m_ptr == NB - 1) m_state = S_RUN;
                m_ptr++;
            end
        end else if (m_state == S_RUN) begin
            if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
            if (bus.MemWrite) begin
                if (a < NB) begin
                    if (bus.ByteMem) m_mem[a[11:0]] = bus.WriteData[7:0];
                    else for (int k = 0; k < 4; k++) m_mem[{a[11:2], 2'b00} + k] = bus.WriteData[8*k +: 8];
                end else if ((a >> 2) == (MB >> 2)) begin
                    m_state = S_DONE;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("start", bus.start, m_state == S_RUN);
        chk("done", bus.done, m_state == S_DONE);
        chk("load_ready", bus.load_ready, m_state == S_LOAD);
    endtask

    task automatic drive_idle();
        bus.MemWrite = 0; bus.ByteMem = 0; bus.ALUResult = 0; bus.WriteData = 0;
        bus.load_valid = 0; bus.load_data = 0; bus.load_last = 0;
    endtask

    task automatic core_op(input logic we, input logic bm, input logic [31:0] a, input logic [31:0] d);
        bus.MemWrite = we; bus.ByteMem = bm; bus.ALUResult = a; bus.WriteData = d;
        #1;
        chk("read_model", bus.ReadData, exp_read(a, bm));
        step();
        bus.MemWrite = 0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic bm, input logic [31:0] exp, input string tag);
        bus.MemWrite = 0; bus.ByteMem = bm; bus.ALUResult = a;
        #1;
        chk(tag, bus.ReadData, exp);
        step();
    endtask

    task automatic load_byte(input logic [7:0] d, input logic last);
        bus.load_valid = 1; bus.load_data = d; bus.load_last = last;
        step();
        bus.load_valid = 0; bus.load_last = 0;
    endtask

    initial begin
        int          r;
        logic [31:0] a;
        logic        we;
        logic [7:0]  nb [6];
        logic [7:0]  rb [4];

        m_state = S_LOAD; m_ptr = 0; m_cycles = 0;
        drive_idle();
        reset = 0;
        step();
        step();
        chk("rst_start", bus.start, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ready", bus.load_ready, 1);
        reset = 1;

        // Full image without load_last: auto transition after the final RAM byte
        for (int i = 0; i < NB * 3 && m_state == S_LOAD; i++) begin
            bus.load_valid = ($urandom_range(0, 3) != 0);
            bus.load_data  = 8'($urandom);
            bus.load_last  = 0;
            step();
        end
        bus.load_valid = 0;
        chk("auto_run_start", bus.start, 1);
        chk("auto_run_ready", bus.load_ready, 0);

        // Host bytes are ignored while running
        for (int i = 0; i < 4; i++) load_byte(8'($urandom), 1'($urandom_range(0, 1)));

        rd_chk(32'h2000, 0, 32'h0, "oor_read");
        core_op(1, 0, 32'h2000, 32'hDEAD_BEEF);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7) a = $urandom_range(0, NB - 1);
            else if (r == 7) a = ($urandom_range(0, 1) != 0) ? 32'h2000 : 32'h0002_0000 + $urandom_range(0, 255);
            else if (r == 8) a = MB + 4;
            else a = MB;
            we = (r <= 7) && ($urandom_range(0, 1) != 0);
            core_op(we, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset while running
        reset = 0;
        drive_idle();
        step();
        chk("rr_start", bus.start, 0);
        chk("rr_ready", bus.load_ready, 1);
        reset = 1;
        rd_chk(MB + 4, 0, 32'h0, "rr_cycles");

        // Short program image with load_last
        load_byte(8'h0C, 0);
        load_byte(8'h00, 0);
        load_byte(8'hA0, 0);
        chk("t1_not_yet", bus.start, 0);
        load_byte(8'hE3, 1);
        chk("t1_start", bus.start, 1);
        chk("t1_ready", bus.load_ready, 0);
        rd_chk(32'h0, 0, 32'hE3A0_000C, "t1_word0");

        core_op(1, 0, 32'h10, 32'h1122_3344);
        core_op(1, 1, 32'h12, 32'h0000_00AB);
        rd_chk(32'h10, 0, 32'h11AB_3344, "t2_word");
        rd_chk(32'h13, 1, 32'h0000_0011, "t2_byte");

        for (int i = 0; i < 100 && m_cycles < 19; i++) core_op(0, 0, $urandom_range(0, NB - 1), 0);
        core_op(1, 0, MB, 32'h1);
        chk("t3_done", bus.done, 1);
        chk("t3_start", bus.start, 0);
        rd_chk(MB, 0, 32'h1, "t3_halt_rd");
        for (int i = 0; i < 10; i++) begin
            rd_chk(MB + 4, 0, 32'd20, "t3_cycles");
            core_op(1, 1'($urandom_range(0, 1)), $urandom_range(0, NB - 1), $urandom);
        end
        rd_chk(MB + 4, 1, 32'd20, "t3_cycles_byte");

        // Memory dump after halt
        for (int w = 0; w < DEPTH; w++) core_op(0, 0, 32'(w * 4), 0);

        // Reset mid-load, partial reload
        reset = 0;
        drive_idle();
        step();
        reset = 1;
        for (int i = 0; i < 6; i++) begin nb[i] = 8'($urandom); load_byte(nb[i], 0); end
        reset = 0;
        step();
        reset = 1;
        for (int i = 0; i < 4; i++) begin rb[i] = 8'($urandom); load_byte(rb[i], i == 3); end
        chk("t5_start", bus.start, 1);
        for (int i = 0; i < 4; i++) rd_chk(32'(i), 1, {24'h0, rb[i]}, "t5_new");
        rd_chk(32'h4, 1, {24'h0, nb[4]}, "t5_old4");
        rd_chk(32'h5, 1, {24'h0, nb[5]}, "t5_old5");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-side responder for the single-cycle ARM core's data bus: RAM, byte-lane handling and a small MMIO region.
- Before execution, a host byte stream loads the program image through a valid/ready handshake.
- After loading, the block raises `start` to release the core. A halt write from the core ends the run.
- Instantiated beside `arm` in the top level; drives `arm.start` and `arm.ReadData`.

Parameters:
DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two)
MMIO_BASE, 32'h0001_0000, base address of the MMIO register block

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
MemWrite  input  1  core store strobe
ByteMem  input  1  1 = byte access (STRB/LDRB), 0 = word access
ALUResult  input  32  core data address
WriteData  input  32  core store data
ReadData  output  32  load data to core, combinational from address
load_valid  input  1  host byte valid
load_data  input  8  host image byte
load_last  input  1  marks final byte of image
load_ready  output  1  block accepts a host byte this cycle
start  output  1  core run enable
done  output  1  program halted

Behaviour:
- FSM states are LOAD, RUN and DONE.
- Reset:
  - State goes to LOAD.
  - Load pointer is 0, cycle counter is 0, start=0, done=0, load_ready=1.
  - RAM contents are not cleared.
- LOAD state:
  - load_ready=1.
  - Each cycle with load_valid=1, the byte is written to byte address ptr, little-endian: word ptr[..2], lane ptr[1:0]. ptr then increments.
  - Accepting a byte with load_last=1 moves the FSM to RUN next cycle.
  - Accepting the byte at ptr = DEPTH_WORDS*4-1 also moves the FSM to RUN, regardless of load_last.
  - Core writes are ignored in LOAD.
- RUN state:
  - start=1 and load_ready=0. Host bytes are ignored.
  - Core accesses are serviced (see core access rules below).
- Core access rules:
  - Word write: MemWrite=1, ByteMem=0. Writes WriteData to word ALUResult[..2]. ALUResult[1:0] is ignored.
  - Byte write: MemWrite=1, ByteMem=1. Writes WriteData[7:0] to lane ALUResult[1:0]. Other lanes are unchanged.
  - Word read: ReadData = word at ALUResult[..2].
  - Byte read: ReadData = {24'b0, selected byte}, zero-extended.
  - Reads are combinational (zero-cycle latency; the core is single-cycle). Writes take effect at the clock edge.
- RAM range is 0 .. DEPTH_WORDS*4-1.
  - Outside RAM and MMIO, reads return 0 and writes are ignored.
- MMIO registers:
  - MMIO_BASE+0 (HALT): reads {31'b0, done}. Any write in RUN moves the FSM to DONE next cycle.
  - MMIO_BASE+4 (CYCLES): read-only. Increments every RUN cycle, including the cycle of the halt write. Saturates at 32'hFFFF_FFFF.
  - ByteMem is ignored for MMIO: a byte read returns the low byte zero-extended.
- DONE state:
  - start=0, done=1, and CYCLES is frozen.
  - Core writes are ignored.
  - Reads are still serviced, so a bench can dump memory through the address port.
  - DONE is held until reset.
- Simultaneous events:
  - load_last on the last RAM byte gives a single transition to RUN.
  - A halt write together with a RAM write is impossible, since addresses are distinct.
  - Reset overrides everything.
- Reset mid-load restarts ptr at 0. Partially loaded bytes stay in RAM and are overwritten by the reload.
- Reset mid-run drops start the same cycle reset is sampled and returns to LOAD.

Test Plan:
1. Load bytes 0x0C,0x00,0xA0,0xE3 with last on the 4th -> word 0 = 0xE3A0000C; start=1 on the cycle after the last accept; load_ready=0.
2. In RUN:
   - Word write 0x11223344 to 0x10.
   - Then byte write 0xAB to 0x12 -> word read at 0x10 = 0x11AB3344.
   - Byte read at 0x13 = 0x00000011.
3. Halt write to 0x0001_0000 after 20 RUN cycles -> done=1 and start=0 next cycle; CYCLES read = 20 and stays 20 for ten more cycles; writes to RAM ignored.
4. Address 0x0000_2000 with DEPTH_WORDS=1024 -> read 0, write leaves all RAM unchanged; holding load_valid without last for 4096 bytes -> auto RUN after byte 4095.
5. Assert reset (0) during LOAD after 6 bytes, reload 4 bytes -> bytes 0-3 are the new values, bytes 4-5 retain old values, ptr restarts at 0.
6. Reset during RUN -> start=0, load_ready=1, CYCLES=0 on the next edge.
